// File: rtl/axi_lite_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI4-Lite read arbiter.
//   state_e      : arbiter FSM encoding (IDLE/ADDR/DATA/ERR)
//   RESP_*       : AXI read response codes used by the arbiter
//   wdog_cnt_width: watchdog counter width for a given limit, clamped to 8..32 bits
package axi_lite_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StErr  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int unsigned wdog_cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    if (w < 8) begin
      w = 8;
    end else if (w > 32) begin
      w = 32;
    end
    return w;
  endfunction

endpackage

// File: rtl/axi_lite_rd_arbiter_if.sv
// One AXI4-Lite read channel (AR + R).
//   master modport: drives arvalid/araddr/rready, receives arready/rvalid/rdata/rresp
//   slave  modport: the opposite direction
interface axi_lite_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_rd_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
//   req        : request vector, bit i = master i
//   last_grant : index granted most recently
//   gnt_valid  : at least one request present
//   gnt_idx    : winning index; on a tie the master other than last_grant wins
module axi_lite_rd_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI4-Lite read arbiter. One transaction outstanding at a time,
// round-robin between masters, AR path registered, R path combinational pass-through.
// Optional watchdog (define ARB_TIMEOUT_EN) turns a hung slave into an SLVERR beat.
//   clk, rst : clock, asynchronous active-high reset
//   m0, m1   : master-facing read channels (slave modport)
//   s        : slave-facing read channel (master modport)
module axi_lite_rd_arbiter
  import axi_lite_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_rd_arbiter_if.slave   m0,
  axi_lite_rd_arbiter_if.slave   m1,
  axi_lite_rd_arbiter_if.master  s
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              pick_valid, pick_idx;
  logic              gnt_rready;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned   CntW   = wdog_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, RESP_SLVERR};
`endif

  axi_lite_rd_arbiter_rr_arb2 u_rr_arb2 (
    .req        ({m1.arvalid, m0.arvalid}),
    .last_grant (last_q),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );

  assign gnt_rready = gnt_q ? m1.rready : m0.rready;
  assign s.araddr   = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // last_q resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      cnt_q  <= '0;
`endif
    end else begin
      addr_q <= addr_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StAddr;
          addr_d  = pick_idx ? m1.araddr : m0.araddr;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StAddr: begin
        if (s.arready) begin
          state_d = StData;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CntMax) state_d = StErr;
        end
`endif
      end
      StData: begin
        if (s.rvalid && gnt_rready) begin
          state_d = StIdle;
        end
`ifdef ARB_TIMEOUT_EN
        // A beat held back by the master is not a slave stall.
        else if (!s.rvalid) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CntMax) state_d = StErr;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      StErr: begin
        if (gnt_rready) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    m0.rdata   = '0;
    m1.rdata   = '0;
    m0.rresp   = RESP_OKAY;
    m1.rresp   = RESP_OKAY;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    unique case (state_q)
      // arready is combinational from arvalid, so hold it low while reset is asserted.
      StIdle: begin
        m0.arready = !rst && pick_valid && !pick_idx;
        m1.arready = !rst && pick_valid && pick_idx;
      end
      StAddr: s.arvalid = 1'b1;
      StData: begin
        s.rready = gnt_rready;
        if (gnt_q) begin
          m1.rvalid = s.rvalid;
          m1.rdata  = s.rdata;
          m1.rresp  = s.rresp;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rdata  = s.rdata;
          m0.rresp  = s.rresp;
        end
      end
`ifdef ARB_TIMEOUT_EN
      // Keep rready high so a late slave beat is swallowed rather than left hanging.
      StErr: begin
        s.rready = 1'b1;
        if (gnt_q) begin
          m1.rvalid = 1'b1;
          m1.rresp  = RESP_SLVERR;
        end else begin
          m0.rvalid = 1'b1;
          m0.rresp  = RESP_SLVERR;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench for axi_lite_rd_arbiter: directed opening read, randomized traffic
// against a transaction-level reference model, mid-transaction reset, and (with
// ARB_TIMEOUT_EN) a hung-slave watchdog run.
module tb_axi_lite_rd_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 16;
  localparam logic [31:0] KEY = 32'h5a5a_c3c3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  axi_lite_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  axi_lite_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  axi_lite_rd_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned err_seen = 0;

  // Master agents
  logic        m_req  [2];
  logic [31:0] m_addr [2];
  logic        m_rdy  [2];
  logic [31:0] m_exp  [2];
  int unsigned p_req  [2];
  // Slave agent
  logic        sl_ar, sl_have, sl_rv;
  logic [31:0] sl_addr, sl_data;
  logic [1:0]  sl_resp;
  int unsigned p_ar, p_rv, p_rr;
  // Transaction-level reference: who holds the slave and how far the transaction has got
  logic        md_busy, md_addr_done, md_err, md_g, md_last;
  logic [31:0] md_addr;
  int unsigned md_stall;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic pct(input int unsigned p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic drive();
    m0_if.arvalid = m_req[0];
    m0_if.araddr  = m_addr[0];
    m0_if.rready  = m_rdy[0];
    m1_if.arvalid = m_req[1];
    m1_if.araddr  = m_addr[1];
    m1_if.rready  = m_rdy[1];
    s_if.arready  = sl_ar;
    s_if.rvalid   = sl_rv;
    s_if.rdata    = sl_rv ? sl_data : $urandom;
    s_if.rresp    = sl_rv ? sl_resp : 2'($urandom_range(3, 0));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_m0_arready"}, 32'(m0_if.arready), 32'd0);
    check_val({tag, "_m1_arready"}, 32'(m1_if.arready), 32'd0);
    check_val({tag, "_m0_rvalid"},  32'(m0_if.rvalid),  32'd0);
    check_val({tag, "_m1_rvalid"},  32'(m1_if.rvalid),  32'd0);
    check_val({tag, "_m0_rdata"},   m0_if.rdata,        32'd0);
    check_val({tag, "_m1_rdata"},   m1_if.rdata,        32'd0);
    check_val({tag, "_m0_rresp"},   32'(m0_if.rresp),   32'd0);
    check_val({tag, "_m1_rresp"},   32'(m1_if.rresp),   32'd0);
    check_val({tag, "_s_arvalid"},  32'(s_if.arvalid),  32'd0);
    check_val({tag, "_s_rready"},   32'(s_if.rready),   32'd0);
    check_val({tag, "_s_araddr"},   s_if.araddr,        32'd0);
  endtask

  task automatic reset_agents(input logic last);
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0;
      m_rdy[i] = 1'b0;
    end
    sl_ar        = 1'b0;
    sl_have      = 1'b0;
    sl_rv        = 1'b0;
    md_busy      = 1'b0;
    md_addr_done = 1'b0;
    md_err       = 1'b0;
    md_g         = 1'b0;
    md_last      = last;
    md_stall     = 0;
  endtask

  task automatic model_stall();
`ifdef ARB_TIMEOUT_EN
    md_stall++;
    if (md_stall >= TO) md_err = 1'b1;
`endif
  endtask

  task automatic run_cycle();
    logic        exp_ar [2];
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    logic [1:0]  exp_rr [2];
    logic        o_ar   [2];
    logic        o_rv   [2];
    logic [31:0] o_rd   [2];
    logic [1:0]  o_rr   [2];
    logic        exp_s_arvalid, exp_s_rready, in_data;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!m_req[i] && pct(p_req[i])) begin
        m_req[i]  = 1'b1;
        m_addr[i] = $urandom;
      end
      m_rdy[i] = pct(p_rr);
    end
    sl_ar = pct(p_ar);
    if (sl_have && !sl_rv && pct(p_rv)) begin
      sl_rv   = 1'b1;
      sl_data = sl_addr ^ KEY;
      sl_resp = pct(30) ? 2'b10 : 2'b00;
    end
    drive();
    #1;
    o_ar[0] = m0_if.arready; o_rv[0] = m0_if.rvalid; o_rd[0] = m0_if.rdata; o_rr[0] = m0_if.rresp;
    o_ar[1] = m1_if.arready; o_rv[1] = m1_if.rvalid; o_rd[1] = m1_if.rdata; o_rr[1] = m1_if.rresp;

    for (int i = 0; i < 2; i++) begin
      exp_ar[i] = 1'b0;
      exp_rv[i] = 1'b0;
      exp_rd[i] = '0;
      exp_rr[i] = 2'b00;
    end
    // Free slave: a lone requester wins; on a tie the master not served last wins.
    if (!md_busy) begin
      if (m_req[0] && m_req[1]) begin
        if (md_last) exp_ar[0] = 1'b1;
        else         exp_ar[1] = 1'b1;
      end else if (m_req[0]) begin
        exp_ar[0] = 1'b1;
      end else if (m_req[1]) begin
        exp_ar[1] = 1'b1;
      end
    end
    in_data       = md_busy && md_addr_done && !md_err;
    exp_s_arvalid = md_busy && !md_addr_done && !md_err;
    if (md_err) begin
      exp_rv[md_g] = 1'b1;
      exp_rr[md_g] = 2'b10;
    end else if (in_data) begin
      exp_rv[md_g] = s_if.rvalid;
      exp_rd[md_g] = s_if.rdata;
      exp_rr[md_g] = s_if.rresp;
    end
    exp_s_rready = md_err ? 1'b1 : (in_data ? m_rdy[md_g] : 1'b0);

    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("m%0d_arready", i), 32'(o_ar[i]), 32'(exp_ar[i]));
      check_val($sformatf("m%0d_rvalid", i),  32'(o_rv[i]), 32'(exp_rv[i]));
      check_val($sformatf("m%0d_rdata", i),   o_rd[i],      exp_rd[i]);
      check_val($sformatf("m%0d_rresp", i),   32'(o_rr[i]), 32'(exp_rr[i]));
    end
    check_val("s_arvalid", 32'(s_if.arvalid), 32'(exp_s_arvalid));
    if (exp_s_arvalid) check_val("s_araddr", s_if.araddr, md_addr);
    check_val("s_rready", 32'(s_if.rready), 32'(exp_s_rready));
    if (in_data && s_if.rvalid && m_rdy[md_g]) check_val("e2e_rdata", o_rd[md_g], m_exp[md_g]);
    if (o_rv[0] && o_rr[0] == 2'b10 && o_rd[0] == 32'd0) err_seen++;

    // Advance agents and reference to the state after the coming clock edge.
    if (exp_s_arvalid && sl_ar) begin
      sl_have = 1'b1;
      sl_addr = s_if.araddr;
    end
    if (sl_rv && exp_s_rready) begin
      sl_rv   = 1'b0;
      sl_have = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (exp_ar[i]) begin
        m_req[i] = 1'b0;
        m_exp[i] = m_addr[i] ^ KEY;
      end
    end
    if (!md_busy) begin
      if (exp_ar[0] || exp_ar[1]) begin
        md_busy      = 1'b1;
        md_addr_done = 1'b0;
        md_err       = 1'b0;
        md_g         = exp_ar[1];
        md_last      = exp_ar[1];
        md_addr      = m_addr[md_g];
        md_stall     = 0;
      end
    end else if (md_err) begin
      if (m_rdy[md_g]) begin
        md_busy = 1'b0;
        md_err  = 1'b0;
        sl_have = 1'b0;
        sl_rv   = 1'b0;
      end
    end else if (!md_addr_done) begin
      if (sl_ar) md_addr_done = 1'b1;
      else       model_stall();
    end else begin
      if (s_if.rvalid && m_rdy[md_g]) md_busy = 1'b0;
      else if (!s_if.rvalid)          model_stall();
    end
  endtask

  task automatic set_knobs(input int unsigned r0, input int unsigned r1, input int unsigned ar,
                           input int unsigned rv, input int unsigned rr);
    p_req[0] = r0;
    p_req[1] = r1;
    p_ar     = ar;
    p_rv     = rv;
    p_rr     = rr;
  endtask

  initial begin
    int unsigned guard;

    m_addr[0] = '0;
    m_addr[1] = '0;
    sl_data   = '0;
    sl_addr   = '0;
    sl_resp   = 2'b00;
    reset_agents(1'b1);
    set_knobs(0, 0, 0, 0, 0);
    drive();
    rst = 1'b1;

    // Reset state, with both masters requesting to prove arready is held low.
    m0_if.arvalid = 1'b1;
    m1_if.arvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");

    // Single m0 read: slave answers in the cycle after each request.
    @(negedge clk);
    rst = 1'b0;
    m0_if.arvalid = 1'b1;
    m0_if.araddr  = 32'h0200_0008;
    m1_if.arvalid = 1'b0;
    m0_if.rready  = 1'b1;
    m1_if.rready  = 1'b1;
    s_if.arready  = 1'b1;
    s_if.rvalid   = 1'b0;
    s_if.rdata    = 32'h0;
    s_if.rresp    = 2'b00;
    #1;
    check_val("d1_m0_arready", 32'(m0_if.arready), 32'd1);
    check_val("d1_m1_arready", 32'(m1_if.arready), 32'd0);
    check_val("d1_c1_s_arvalid", 32'(s_if.arvalid), 32'd0);
    @(negedge clk);
    m0_if.arvalid = 1'b0;
    #1;
    check_val("d1_s_arvalid", 32'(s_if.arvalid), 32'd1);
    check_val("d1_s_araddr", s_if.araddr, 32'h0200_0008);
    check_val("d1_c2_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    @(negedge clk);
    s_if.rvalid = 1'b1;
    s_if.rdata  = 32'h0000_1234;
    #1;
    check_val("d1_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    check_val("d1_m0_rdata", m0_if.rdata, 32'h0000_1234);
    check_val("d1_m0_rresp", 32'(m0_if.rresp), 32'd0);
    check_val("d1_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    check_val("d1_m1_rdata", m1_if.rdata, 32'd0);
    check_val("d1_s_rready", 32'(s_if.rready), 32'd1);
    @(negedge clk);
    s_if.rvalid = 1'b0;
    #1;
    check_val("d1_c4_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    check_val("d1_c4_s_arvalid", 32'(s_if.arvalid), 32'd0);

    // m0 was served last, so the next tie goes to m1.
    reset_agents(1'b0);
    set_knobs(100, 100, 100, 100, 100);
    repeat (24) run_cycle();
    set_knobs(40, 60, 60, 50, 60);
    repeat (1500) run_cycle();
    set_knobs(70, 70, 20, 25, 30);
    repeat (400) run_cycle();

    // Park a transaction in the data phase, then reset underneath it.
    set_knobs(100, 100, 100, 0, 50);
    guard = 0;
    while (!(md_busy && md_addr_done && !md_err) && guard < 200) begin
      run_cycle();
      guard++;
    end
    check_val("reach_data", 32'(md_busy && md_addr_done && !md_err), 32'd1);
    @(negedge clk);
    s_if.rvalid   = 1'b1;
    s_if.rdata    = 32'hdead_beef;
    s_if.rresp    = 2'b01;
    m0_if.rready  = 1'b0;
    m1_if.rready  = 1'b0;
    m0_if.arvalid = 1'b1;
    m1_if.arvalid = 1'b1;
    #1;
    check_val("pre_rst_rvalid", 32'(md_g ? m1_if.rvalid : m0_if.rvalid), 32'd1);
    check_val("pre_rst_rdata", md_g ? m1_if.rdata : m0_if.rdata, 32'hdead_beef);
    #1 rst = 1'b1;
    #1 check_all_zero("rst_data");
    @(negedge clk);
    #1 check_all_zero("rst_hold");
    reset_agents(1'b1);
    drive();
    rst = 1'b0;
    set_knobs(100, 100, 70, 60, 70);
    repeat (60) run_cycle();

`ifdef ARB_TIMEOUT_EN
    // Slave never returns data: every grant should end in an SLVERR beat.
    set_knobs(100, 0, 100, 0, 100);
    err_seen = 0;
    repeat (80) run_cycle();
    check_val("wdog_slverr_seen", 32'(err_seen > 0), 32'd1);
    set_knobs(50, 50, 80, 80, 80);
    repeat (60) run_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_rd_arbiter.md
# axi_lite_rd_arbiter

Two-master, one-slave AXI4-Lite read-channel arbiter that shares a single read-only peripheral port, such as the CLINT mtime port, between the instruction fetch unit (master 0) and the load/store unit (master 1). It grants one read transaction at a time using round-robin priority. It forwards the address to the slave and routes the data beat back to the granted master. An optional watchdog converts a hung slave into an SLVERR response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- m0_arvalid / m1_arvalid  in  1  master read-address valid
- m0_arready / m1_arready  out  1  master read-address ready
- m0_araddr / m1_araddr  in  ADDR_W  master read address
- m0_rvalid / m1_rvalid  out  1  master read-data valid
- m0_rready / m1_rready  in  1  master read-data ready
- m0_rdata / m1_rdata  out  DATA_W  master read data
- m0_rresp / m1_rresp  out  2  master read response
- s_arvalid  out  1  slave read-address valid
- s_arready  in  1  slave read-address ready
- s_araddr  out  ADDR_W  slave read address (registered)
- s_rvalid  in  1  slave read-data valid
- s_rready  out  1  slave read-data ready
- s_rdata  in  DATA_W  slave read data
- s_rresp  in  2  slave read response

## Operation
- FSM states: IDLE, ADDR, DATA, ERR. Only one transaction is outstanding at any time.
- IDLE:
  - Arbitration: if exactly one mX_arvalid is high, that master is granted. If both are high, the master other than last_grant wins.
  - mX_arready = 1 combinationally for the granted master only. The AR handshake completes in the same cycle.
  - On the handshake: addr_r <= mX_araddr, gnt_r <= X, last_grant <= X, then go to ADDR.
- ADDR:
  - s_arvalid = 1 and s_araddr = addr_r.
  - On s_arready, go to DATA.
  - Both mX_arready are 0.
- DATA:
  - Granted master: mX_rvalid = s_rvalid, mX_rdata = s_rdata, mX_rresp = s_rresp.
  - s_rready = mX_rready of the granted master.
  - On s_rvalid && s_rready, go to IDLE.
- The non-granted master always sees rvalid = 0, rdata = 0, rresp = 0.
- No requests are accepted outside IDLE. An mX_arvalid that is held pending stays pending and is arbitrated on return to IDLE.
- Reset (including mid-transaction):
  - FSM goes to IDLE; addr_r = 0; gnt_r = 0; last_grant = 1, so m0 wins the first tie.
  - All valid/ready outputs are 0 and all data/resp outputs are 0.
  - An in-flight transaction is abandoned without a response.

## Timing
- Master AR accepted at cycle T; s_arvalid is high from cycle T+1.
- Minimum round trip is 3 cycles from mX_arvalid to mX_rvalid, when the slave gives arready and rvalid in the cycle after each request.
- R path is combinational pass-through (zero added latency); AR path is one register stage.
- Back-to-back grants: the earliest next AR acceptance is the cycle after the R handshake (IDLE re-entered).
- A simultaneous request on the IDLE cycle immediately following m0's grant goes to m1.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8..32-bit counter clears on entry to ADDR.
  - It increments each cycle in ADDR while !s_arready, and in DATA while !s_rvalid.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to ERR.
- ERR state:
  - Granted master sees rvalid = 1, rdata = 0, rresp = 2'b10 (SLVERR).
  - s_arvalid = 0 and s_rready = 1, so a late beat is absorbed.
  - Go to IDLE on mX_rready.
  - A slave beat arriving after ERR has been left is a protocol violation; the slave is treated as hung.
- ARB_TIMEOUT_EN undefined: no counter and no ERR state; the arbiter waits indefinitely in ADDR/DATA.

## Structure
- Shared package holds:
  - state encoding (IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR = 2'd3)
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
- Sub-module rr_arb2: a purely combinational two-way round-robin picker with inputs req[1:0] and last_grant, and outputs gnt_valid and gnt_idx.
- Top level holds the FSM, address/grant registers, muxing and the optional watchdog.

## Test plan
- Single m0 read of 0x0200_0008; slave returns 0x0000_1234 OKAY one cycle after each request -> m0_rdata = 0x1234, rresp = 0, m0_rvalid in cycle 3, and m1 stays idle.
- Both arvalid high at the first cycle after reset -> m0 granted first. When both are re-asserted, m1 gets the second grant, and grants alternate m0/m1 over 4 transactions.
- Slave holds s_arready low for 5 cycles -> s_arvalid and s_araddr are stable throughout, with no mX_rvalid until the slave responds.
- m1 holds m1_rready low for 3 cycles while s_rvalid is high -> s_rready stays low, data is stable, and the R handshake completes on the cycle rready rises.
- rst asserted in DATA -> all outputs are 0 in the same cycle; after release, a pending m1 request and m0 request tie and m0 is granted.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the slave never raises s_rvalid -> m0 gets rvalid with rresp = 2'b10 and rdata = 0 about 16 cycles after s_arready, then the FSM returns to IDLE.
